// File: rtl/axis_checker_pkg.sv
// Shared types and flit field helpers for the AXI-Stream latency checker endpoint.
package axis_checker_pkg;

  // Bit positions inside err_code
  typedef enum int unsigned {
    ERR_SEQ       = 0,
    ERR_DEST      = 1,
    ERR_TID_RANGE = 2,
    ERR_FRAMING   = 3
  } err_bit_e;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } fsm_e;

  localparam int unsigned ERR_W     = 4;
  localparam logic [15:0] LFSR_SEED = 16'h00A5;

  // LSB of the sent timestamp, which occupies the top of the head flit
  function automatic int unsigned sent_tick_lsb(input int unsigned tdata_w, input int unsigned tick_w);
    return tdata_w - tick_w;
  endfunction

  // MSB of the sequence number, which occupies the bottom of the head flit
  function automatic int unsigned seq_msb(input int unsigned count_w);
    return count_w - 1;
  endfunction

endpackage

// File: rtl/axis_latency_checker_if.sv
// AXI-Stream link from a router egress port into the checker endpoint.
interface axis_latency_checker_if #(
  parameter int unsigned TDATA_WIDTH = 512,
  parameter int unsigned TID_WIDTH   = 2,
  parameter int unsigned TDEST_WIDTH = 2
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tlast;
  logic [TID_WIDTH-1:0]   tid;
  logic [TDEST_WIDTH-1:0] tdest;

  modport master (output tvalid, tdata, tlast, tid, tdest, input tready);
  modport slave  (input tvalid, tdata, tlast, tid, tdest, output tready);
endinterface

// File: rtl/lfsr_stall_gen.sv
// Backpressure generator: free-running 16-bit Fibonacci LFSR drives a registered ready.
module lfsr_stall_gen
  import axis_checker_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] stall_mode,
  input  logic [7:0] stall_thresh,
  output logic       stall_n
);

  logic [15:0] lfsr_q;
  logic        fb_c;

  // Taps 16,14,13,11
  assign fb_c = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // LFSR steps every cycle; ready is a flop so it never depends on tvalid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q  <= LFSR_SEED;
      stall_n <= 1'b0;
    end else begin
      lfsr_q <= {lfsr_q[14:0], fb_c};
      case (stall_mode)
        2'd1:    stall_n <= (lfsr_q[7:0] >= stall_thresh);
        2'd2:    stall_n <= 1'b0;
        default: stall_n <= 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/axis_latency_checker.sv
// NoC endpoint sink: framing/sequence/dest checks, latency statistics and backpressure.
module axis_latency_checker
  import axis_checker_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH = 512,
  parameter int unsigned TID_WIDTH   = 2,
  parameter int unsigned TDEST_WIDTH = 2,
  parameter int unsigned TDEST       = 0,
  parameter int unsigned NUM_SRCS    = 4,
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned TICK_WIDTH  = 64,
  parameter int unsigned HIST_BINS   = 16,
  parameter int unsigned BIN_SHIFT   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [TICK_WIDTH-1:0]  ticks,
  input  logic                   stat_clear,
  input  logic [1:0]             stall_mode,
  input  logic [7:0]             stall_thresh,
  axis_latency_checker_if.slave  axis_in,
  output logic [COUNT_WIDTH-1:0] recv_packets [NUM_SRCS],
  output logic [COUNT_WIDTH-1:0] total_packets,
  output logic [COUNT_WIDTH-1:0] total_flits,
  output logic [TICK_WIDTH-1:0]  total_latency,
  output logic [TICK_WIDTH-1:0]  min_latency,
  output logic [TICK_WIDTH-1:0]  max_latency,
  output logic [COUNT_WIDTH-1:0] hist [HIST_BINS],
  output logic [TICK_WIDTH-1:0]  first_tick,
  output logic [TICK_WIDTH-1:0]  last_tick,
  output logic                   error,
  output logic [ERR_W-1:0]       err_code,
  output logic [TID_WIDTH-1:0]   err_tid,
  output logic [COUNT_WIDTH-1:0] err_expected,
  output logic [COUNT_WIDTH-1:0] err_got
);

  localparam int unsigned NUM_TIDS = 2 ** TID_WIDTH;
  localparam int unsigned SRC_W    = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;
  localparam int unsigned BIN_W    = $clog2(HIST_BINS);
  localparam int unsigned SENT_LSB = sent_tick_lsb(TDATA_WIDTH, TICK_WIDTH);
  localparam int unsigned SEQ_MSB  = seq_msb(COUNT_WIDTH);

  fsm_e                   state_q;
  logic [TID_WIDTH-1:0]   head_tid_q;
  logic [TICK_WIDTH-1:0]  sent_q;
  logic [COUNT_WIDTH-1:0] expected_q [NUM_TIDS];
  logic                   first_seen_q;
  logic                   pend_vld_q;
  logic                   pend_ok_q;
  logic [SRC_W-1:0]       pend_src_q;
  logic [TICK_WIDTH-1:0]  pend_lat_q;
  logic                   stall_n;

  logic                   acc_c;
  logic                   head_c;
  logic                   tail_c;
  logic                   tid_ok_c;
  logic                   pkt_ok_c;
  logic [TID_WIDTH-1:0]   pkt_tid_c;
  logic [COUNT_WIDTH-1:0] seq_c;
  logic [COUNT_WIDTH-1:0] exp_c;
  logic [TICK_WIDTH-1:0]  beat_sent_c;
  logic [TICK_WIDTH-1:0]  lat_c;
  logic [TICK_WIDTH-1:0]  lat_bin_c;
  logic [BIN_W-1:0]       bin_c;
  logic [ERR_W-1:0]       new_err_c;
  logic                   unused_tdata_c;

  lfsr_stall_gen u_stall (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_mode   (stall_mode),
    .stall_thresh (stall_thresh),
    .stall_n      (stall_n)
  );

  assign axis_in.tready = stall_n;
  assign unused_tdata_c = ^axis_in.tdata[SENT_LSB-1:SEQ_MSB+1];

  // Beat classification, head checks, tail latency and histogram bin selection
  always_comb begin
    acc_c       = axis_in.tvalid && axis_in.tready;
    head_c      = acc_c && (state_q == IDLE);
    tail_c      = acc_c && axis_in.tlast;
    seq_c       = axis_in.tdata[SEQ_MSB:0];
    beat_sent_c = axis_in.tdata[SENT_LSB +: TICK_WIDTH];
    exp_c       = expected_q[axis_in.tid];
    tid_ok_c    = 32'(axis_in.tid) < NUM_SRCS;
    pkt_tid_c   = (state_q == IDLE) ? axis_in.tid : head_tid_q;
    pkt_ok_c    = 32'(pkt_tid_c) < NUM_SRCS;
    lat_c       = ticks - ((state_q == IDLE) ? beat_sent_c : sent_q);
    new_err_c   = '0;
    if (head_c) begin
      new_err_c[ERR_DEST]      = (axis_in.tdest != TDEST_WIDTH'(TDEST));
      new_err_c[ERR_TID_RANGE] = !tid_ok_c;
      new_err_c[ERR_SEQ]       = tid_ok_c && (seq_c != exp_c);
    end else if (acc_c && (axis_in.tid != head_tid_q)) begin
      new_err_c[ERR_FRAMING] = 1'b1;
    end
    lat_bin_c = pend_lat_q >> BIN_SHIFT;
    bin_c     = (lat_bin_c > TICK_WIDTH'(HIST_BINS - 1)) ? BIN_W'(HIST_BINS - 1) : lat_bin_c[BIN_W-1:0];
  end

  // Framing FSM and head capture; keeps advancing through stat_clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      head_tid_q <= '0;
      sent_q     <= '0;
    end else if (acc_c) begin
      if (state_q == IDLE) begin
        head_tid_q <= axis_in.tid;
        sent_q     <= beat_sent_c;
        state_q    <= axis_in.tlast ? IDLE : BODY;
      end else if (axis_in.tlast) begin
        state_q <= IDLE;
      end
    end
  end

  // Flit/tick bookkeeping, expected sequence tracking, sticky errors, tail latency staging
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clear) begin
      total_flits  <= '0;
      first_tick   <= '0;
      last_tick    <= '0;
      first_seen_q <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_ok_q    <= 1'b0;
      pend_src_q   <= '0;
      pend_lat_q   <= '0;
      error        <= 1'b0;
      err_code     <= '0;
      err_tid      <= '0;
      err_expected <= '0;
      err_got      <= '0;
      expected_q   <= '{default: '0};
    end else begin
      pend_vld_q <= tail_c;
      if (acc_c) total_flits <= total_flits + COUNT_WIDTH'(1);
      if (head_c) begin
        if (!first_seen_q) begin
          first_tick   <= ticks;
          first_seen_q <= 1'b1;
        end
        // Match or resync both leave expected at seq+1
        if (tid_ok_c) expected_q[axis_in.tid] <= seq_c + COUNT_WIDTH'(1);
      end
      if (tail_c) begin
        last_tick  <= ticks;
        pend_ok_q  <= pkt_ok_c;
        pend_src_q <= SRC_W'(pkt_tid_c);
        pend_lat_q <= lat_c;
      end
      if (|new_err_c) begin
        error    <= 1'b1;
        err_code <= err_code | new_err_c;
        if (err_code == '0) begin
          err_tid      <= axis_in.tid;
          err_expected <= head_c ? exp_c : '0;
          err_got      <= head_c ? seq_c : '0;
        end
      end
    end
  end

  // Packet statistics, one cycle after the tail beat
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clear) begin
      recv_packets  <= '{default: '0};
      hist          <= '{default: '0};
      total_packets <= '0;
      total_latency <= '0;
      min_latency   <= '1;
      max_latency   <= '0;
    end else if (pend_vld_q) begin
      total_packets <= total_packets + COUNT_WIDTH'(1);
      total_latency <= total_latency + pend_lat_q;
      if (pend_lat_q < min_latency) min_latency <= pend_lat_q;
      if (pend_lat_q > max_latency) max_latency <= pend_lat_q;
      if (pend_ok_q) recv_packets[pend_src_q] <= recv_packets[pend_src_q] + COUNT_WIDTH'(1);
      if (hist[bin_c] != '1) hist[bin_c] <= hist[bin_c] + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_axis_latency_checker.sv
// Directed + randomized bench for axis_latency_checker with a packet-level reference model.
module tb_axis_latency_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] ticks;
  logic        stat_clear;
  logic [1:0]  stall_mode;
  logic [7:0]  stall_thresh;

  logic [31:0] recv_packets [4];
  logic [31:0] total_packets, total_flits;
  logic [63:0] total_latency, min_latency, max_latency;
  logic [31:0] hist [16];
  logic [63:0] first_tick, last_tick;
  logic        error;
  logic [3:0]  err_code;
  logic [1:0]  err_tid;
  logic [31:0] err_expected, err_got;

  // Reference model state
  logic [31:0] m_recv [4];
  logic [31:0] m_hist [16];
  logic [31:0] m_exp [4];
  logic [31:0] m_pk, m_flits, m_err_exp, m_err_got;
  logic [63:0] m_sum, m_min, m_max, m_first, m_last;
  logic        m_first_seen;
  logic [3:0]  m_err;
  logic [1:0]  m_err_tid;

  int tests;
  int fails;

  axis_latency_checker_if #(.TDATA_WIDTH(512), .TID_WIDTH(2), .TDEST_WIDTH(2)) bus ();

  axis_latency_checker #(
    .TDATA_WIDTH(512), .TID_WIDTH(2), .TDEST_WIDTH(2), .TDEST(0), .NUM_SRCS(4),
    .COUNT_WIDTH(32), .TICK_WIDTH(64), .HIST_BINS(16), .BIN_SHIFT(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ticks         (ticks),
    .stat_clear    (stat_clear),
    .stall_mode    (stall_mode),
    .stall_thresh  (stall_thresh),
    .axis_in       (bus),
    .recv_packets  (recv_packets),
    .total_packets (total_packets),
    .total_flits   (total_flits),
    .total_latency (total_latency),
    .min_latency   (min_latency),
    .max_latency   (max_latency),
    .hist          (hist),
    .first_tick    (first_tick),
    .last_tick     (last_tick),
    .error         (error),
    .err_code      (err_code),
    .err_tid       (err_tid),
    .err_expected  (err_expected),
    .err_got       (err_got)
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge; the global timestamp moves once per cycle
  task automatic step();
    @(negedge clk);
    ticks = ticks + 64'd1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_recv[i] = '0;
      m_exp[i]  = '0;
    end
    for (int i = 0; i < 16; i++) m_hist[i] = '0;
    m_pk = '0; m_flits = '0; m_sum = '0; m_min = '1; m_max = '0;
    m_first = '0; m_last = '0; m_first_seen = 1'b0;
    m_err = '0; m_err_tid = '0; m_err_exp = '0; m_err_got = '0;
  endtask

  task automatic rec_err(input logic [3:0] bits, input logic [1:0] tid, input logic [31:0] e, input logic [31:0] g);
    if (bits != 4'd0) begin
      if (m_err == 4'd0) begin
        m_err_tid = tid;
        m_err_exp = e;
        m_err_got = g;
      end
      m_err = m_err | bits;
    end
  endtask

  task automatic check_all(input string tag);
    chk($sformatf("%s.total_packets", tag), 64'(total_packets), 64'(m_pk));
    chk($sformatf("%s.total_flits", tag), 64'(total_flits), 64'(m_flits));
    chk($sformatf("%s.total_latency", tag), total_latency, m_sum);
    chk($sformatf("%s.min_latency", tag), min_latency, m_min);
    chk($sformatf("%s.max_latency", tag), max_latency, m_max);
    chk($sformatf("%s.first_tick", tag), first_tick, m_first);
    chk($sformatf("%s.last_tick", tag), last_tick, m_last);
    chk($sformatf("%s.error", tag), 64'(error), 64'(m_err != 4'd0));
    chk($sformatf("%s.err_code", tag), 64'(err_code), 64'(m_err));
    chk($sformatf("%s.err_tid", tag), 64'(err_tid), 64'(m_err_tid));
    chk($sformatf("%s.err_expected", tag), 64'(err_expected), 64'(m_err_exp));
    chk($sformatf("%s.err_got", tag), 64'(err_got), 64'(m_err_got));
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s.recv_packets[%0d]", tag, i), 64'(recv_packets[i]), 64'(m_recv[i]));
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s.hist[%0d]", tag, i), 64'(hist[i]), 64'(m_hist[i]));
  endtask

  // Present one beat, wait (bounded) for ready, return the timestamp at acceptance
  task automatic do_beat(input logic [1:0] tid, input logic [1:0] dest, input logic last,
                         input logic [511:0] data, input logic clr, output logic [63:0] t);
    int waited;
    waited = 0;
    bus.tvalid = 1'b1; bus.tid = tid; bus.tdest = dest; bus.tlast = last; bus.tdata = data;
    while (!bus.tready && waited < 300) begin
      step();
      waited++;
    end
    if (waited >= 300) chk("tready_timeout", 64'(bus.tready), 64'd1);
    stat_clear = clr;
    t = ticks;
    step();
    bus.tvalid = 1'b0; bus.tlast = 1'b0; stat_clear = 1'b0;
  endtask

  // Send a whole packet and fold its outcome into the model
  task automatic send_packet(input logic [1:0] tid, input logic [31:0] seq, input int n, input int off,
                             input logic [1:0] dest, input int sw, input logic clr_tail);
    logic [63:0]  sent, t, head_t, lat;
    logic [511:0] d;
    logic [3:0]   herr;
    int           bin;
    sent = ticks - 64'(off);
    head_t = '0;
    t = '0;
    for (int b = 0; b < n; b++) begin
      d = {16{$urandom()}};
      if (b == 0) begin
        d[511 -: 64] = sent;
        d[31:0] = seq;
      end
      do_beat((b == sw) ? (tid ^ 2'd1) : tid, dest, b == n - 1, d, clr_tail && (b == n - 1), t);
      if (b == 0) head_t = t;
    end
    if (clr_tail) begin
      model_clear();
    end else begin
      m_flits = m_flits + 32'(n);
      if (!m_first_seen) begin
        m_first = head_t;
        m_first_seen = 1'b1;
      end
      herr = '0;
      if (dest != 2'd0) herr[1] = 1'b1;
      if (seq != m_exp[tid]) herr[0] = 1'b1;
      rec_err(herr, tid, m_exp[tid], seq);
      if (sw > 0 && sw < n) rec_err(4'b1000, tid ^ 2'd1, 32'd0, 32'd0);
      m_exp[tid] = seq + 32'd1;
      lat = t - sent;
      m_pk = m_pk + 32'd1;
      m_recv[tid] = m_recv[tid] + 32'd1;
      m_sum = m_sum + lat;
      if (lat < m_min) m_min = lat;
      if (lat > m_max) m_max = lat;
      if ((lat >> 2) > 64'd15) bin = 15;
      else bin = int'(32'(lat >> 2));
      m_hist[bin] = m_hist[bin] + 32'd1;
      m_last = t;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.tvalid = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    model_clear();
    repeat (2) step();
  endtask

  task automatic pulse_clear();
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [63:0]  t;
    logic [511:0] d;
    logic [31:0]  rs [4];
    int           low, high;
    logic [1:0]   tid;

    tests = 0; fails = 0;
    ticks = 64'd1000; stat_clear = 1'b0; stall_mode = 2'd0; stall_thresh = 8'd0; rst_n = 1'b0;
    bus.tvalid = 1'b0; bus.tdata = '0; bus.tlast = 1'b0; bus.tid = '0; bus.tdest = '0;

    // Reset state
    do_reset();
    check_all("reset");

    // Three single-flit packets from source 1, latency 10 each
    for (int s = 0; s < 3; s++) send_packet(2'd1, 32'(s), 1, 10, 2'd0, -1, 1'b0);
    step(); step();
    check_all("single");
    chk("single.recv1", 64'(recv_packets[1]), 64'd3);
    chk("single.sum", total_latency, 64'd30);
    chk("single.min", min_latency, 64'd10);
    chk("single.max", max_latency, 64'd10);
    chk("single.hist2", 64'(hist[2]), 64'd3);
    chk("single.error", 64'(error), 64'd0);

    // Four-flit packet: head at tick 100 sent at 90, tail at 103
    pulse_clear();
    ticks = 64'd100;
    send_packet(2'd2, 32'd0, 4, 10, 2'd0, -1, 1'b0);
    step(); step();
    check_all("multi");
    chk("multi.sum", total_latency, 64'd13);
    chk("multi.flits", 64'(total_flits), 64'd4);
    chk("multi.pkts", 64'(total_packets), 64'd1);
    chk("multi.hist3", 64'(hist[3]), 64'd1);

    // Sequence gap on source 0, then resynced sequence
    pulse_clear();
    send_packet(2'd0, 32'd0, 1, 5, 2'd0, -1, 1'b0);
    send_packet(2'd0, 32'd2, 1, 5, 2'd0, -1, 1'b0);
    step(); step();
    chk("seq.err_code", 64'(err_code), 64'h1);
    chk("seq.err_tid", 64'(err_tid), 64'd0);
    chk("seq.err_expected", 64'(err_expected), 64'd1);
    chk("seq.err_got", 64'(err_got), 64'd2);
    send_packet(2'd0, 32'd3, 2, 5, 2'd0, -1, 1'b0);
    step(); step();
    chk("seq.resync_code", 64'(err_code), 64'h1);
    check_all("seq");

    // Wrong dest on the head, then a tid switch mid-packet
    pulse_clear();
    send_packet(2'd3, 32'd0, 1, 6, 2'd0, -1, 1'b0);
    send_packet(2'd3, 32'd1, 3, 6, 2'd1, 1, 1'b0);
    step(); step();
    chk("dest.err_code", 64'(err_code), 64'hA);
    chk("dest.err_tid", 64'(err_tid), 64'd3);
    chk("dest.err_expected", 64'(err_expected), 64'd1);
    chk("dest.err_got", 64'(err_got), 64'd1);
    check_all("dest");

    // Clear coincident with a tail beat, then a normal packet
    pulse_clear();
    send_packet(2'd0, 32'd0, 1, 7, 2'd0, -1, 1'b0);
    send_packet(2'd1, 32'd0, 2, 7, 2'd0, -1, 1'b1);
    step(); step();
    chk("clrtail.pkts", 64'(total_packets), 64'd0);
    chk("clrtail.min", min_latency, 64'hFFFF_FFFF_FFFF_FFFF);
    check_all("clrtail");
    send_packet(2'd0, 32'd0, 1, 9, 2'd0, -1, 1'b0);
    step(); step();
    chk("clrtail.recv0", 64'(recv_packets[0]), 64'd1);
    chk("clrtail.sum", total_latency, 64'd9);
    check_all("after_clr");

    // Reset mid-packet: next beat must be a head
    d = '0;
    d[511 -: 64] = ticks;
    do_beat(2'd2, 2'd0, 1'b0, d, 1'b0, t);
    do_reset();
    send_packet(2'd2, 32'd0, 1, 4, 2'd0, -1, 1'b0);
    step(); step();
    chk("midrst.pkts", 64'(total_packets), 64'd1);
    check_all("midrst");

    // Random traffic under random backpressure
    pulse_clear();
    stall_mode = 2'd1;
    stall_thresh = 8'd128;
    for (int i = 0; i < 4; i++) rs[i] = '0;
    for (int p = 0; p < 80; p++) begin
      tid = 2'($urandom_range(0, 3));
      send_packet(tid, rs[tid], int'($urandom_range(1, 4)), int'($urandom_range(0, 80)), 2'd0, -1, 1'b0);
      rs[tid] = rs[tid] + 32'd1;
      if ($urandom_range(0, 3) == 0) step();
    end
    step(); step();
    check_all("rand");
    chk("rand.err_code", 64'(err_code), 64'd0);

    // Duty cycle of ready in random mode
    low = 0;
    for (int c = 0; c < 10000; c++) begin
      step();
      if (!bus.tready) low++;
    end
    chk("stall.ratio_in_range", 64'(low >= 4000 && low <= 6000), 64'd1);

    // Never ready
    stall_mode = 2'd2;
    step(); step();
    high = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (bus.tready) high++;
    end
    chk("mode2.ready_high_cycles", 64'(high), 64'd0);

    // Reserved mode behaves as always ready
    stall_mode = 2'd3;
    step(); step();
    chk("mode3.tready", 64'(bus.tready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
